// File: rtl/note_lane_scheduler.sv
`default_nettype none
// ============================================================================
// note_lane_scheduler: beat-driven pattern fetch, note slot allocation,
// frame-tick scrolling, bottom retire and per-lane hit arbitration.
// Revision: 1.0
// ============================================================================
module note_lane_scheduler #(
  parameter int POS_W          = 10,
  parameter int SLOTS_PER_LANE = 3,
  parameter int SPAWN_Y        = 20,
  parameter int STEP           = 1,
  parameter int BOTTOM         = 460,
  parameter int HIT_LO         = 400,
  parameter int HIT_HI         = 440,
  parameter int PAT_AW         = 3
) (
  input  logic                                  board_clk,
  input  logic                                  reset,
  input  logic                                  run_i,
  input  logic                                  beat_tick_i,
  input  logic                                  frame_tick_i,
  input  logic [2:0]                            hit_req_i,
  output logic [PAT_AW-1:0]                     pat_addr_o,
  input  logic [2:0]                            pat_data_i,
  output logic [3*SLOTS_PER_LANE-1:0]           slot_active_o,
  output logic [3*SLOTS_PER_LANE*POS_W-1:0]     slot_pos_o,
  output logic                                  hit_pulse_o,
  output logic                                  miss_pulse_o,
  output logic                                  overflow_pulse_o,
  output logic [7:0]                            score_o
);

  localparam int NS = 3 * SLOTS_PER_LANE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_SPAWN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_AW-1:0]   pat_addr_q, pat_addr_d;
  logic [NS-1:0]       active_q, active_d;
  logic [POS_W-1:0]    pos_q [NS];
  logic [POS_W-1:0]    pos_d [NS];
  logic [7:0]          score_q, score_d;
  logic                hit_pulse_q, miss_pulse_q, ovf_pulse_q;

  logic [NS-1:0]       hit_sel, spawn_sel;
  logic [1:0]          hit_cnt;
  logic                ovf, miss;
  logic [9:0]          score_sum;

  // FSM next state and pattern address
  always_comb begin
    state_d    = state_q;
    pat_addr_d = pat_addr_q;
    case (state_q)
      S_IDLE:  if (beat_tick_i && run_i) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_SPAWN;
      S_SPAWN: begin
        state_d    = S_IDLE;
        pat_addr_d = pat_addr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane L maps to bit 2-L of hit_req/pat_data (red lane owns the lowest slots).
  // Free-ness and window membership use start-of-cycle state only.
  always_comb begin
    logic found_hit;
    logic found_free;
    int   k;
    hit_sel    = '0;
    spawn_sel  = '0;
    hit_cnt    = 2'd0;
    ovf        = 1'b0;
    found_hit  = 1'b0;
    found_free = 1'b0;
    k          = 0;
    for (int l = 0; l < 3; l++) begin
      found_hit  = 1'b0;
      found_free = 1'b0;
      for (int s = 0; s < SLOTS_PER_LANE; s++) begin
        k = l * SLOTS_PER_LANE + s;
        if (run_i && hit_req_i[2-l] && !found_hit && active_q[k] &&
            pos_q[k] >= POS_W'(HIT_LO) && pos_q[k] <= POS_W'(HIT_HI)) begin
          hit_sel[k] = 1'b1;
          found_hit  = 1'b1;
        end
        if (state_q == S_SPAWN && pat_data_i[2-l] && !found_free && !active_q[k]) begin
          spawn_sel[k] = 1'b1;
          found_free   = 1'b1;
        end
      end
      if (found_hit) hit_cnt = hit_cnt + 2'd1;
      if (state_q == S_SPAWN && pat_data_i[2-l] && !found_free) ovf = 1'b1;
    end
  end

  always_comb begin
    logic [POS_W:0] adv;
    active_d = active_q;
    miss     = 1'b0;
    adv      = '0;
    for (int k = 0; k < NS; k++) begin
      pos_d[k] = pos_q[k];
      adv      = {1'b0, pos_q[k]} + (POS_W+1)'(STEP);
      if (spawn_sel[k]) begin
        active_d[k] = 1'b1;
        pos_d[k]    = POS_W'(SPAWN_Y);
      end else if (active_q[k]) begin
        if (hit_sel[k]) begin
          active_d[k] = 1'b0;
          pos_d[k]    = '0;
        end else if (frame_tick_i && run_i) begin
          if (adv > (POS_W+1)'(BOTTOM)) begin
            active_d[k] = 1'b0;
            pos_d[k]    = '0;
            miss        = 1'b1;
          end else begin
            pos_d[k] = adv[POS_W-1:0];
          end
        end
      end
    end
  end

  assign score_sum = {2'b00, score_q} + {8'h00, hit_cnt};
  assign score_d   = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pat_addr_q   <= '0;
      active_q     <= '0;
      score_q      <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      ovf_pulse_q  <= 1'b0;
      for (int k = 0; k < NS; k++) pos_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      pat_addr_q   <= pat_addr_d;
      active_q     <= active_d;
      score_q      <= score_d;
      hit_pulse_q  <= |hit_sel;
      miss_pulse_q <= miss;
      ovf_pulse_q  <= ovf;
      for (int k = 0; k < NS; k++) pos_q[k] <= pos_d[k];
    end
  end

  generate
    for (genvar g = 0; g < NS; g++) begin : g_pos
      assign slot_pos_o[g*POS_W +: POS_W] = pos_q[g];
    end
  endgenerate

  assign pat_addr_o       = pat_addr_q;
  assign slot_active_o    = active_q;
  assign hit_pulse_o      = hit_pulse_q;
  assign miss_pulse_o     = miss_pulse_q;
  assign overflow_pulse_o = ovf_pulse_q;
  assign score_o          = score_q;

endmodule
`default_nettype wire

// File: tb/tb_note_lane_scheduler.sv
`default_nettype none
// ============================================================================
// tb_note_lane_scheduler: directed bench for note_lane_scheduler.
// Revision: 1.0
// ============================================================================
module tb_note_lane_scheduler;

  logic        board_clk = 1'b0;
  logic        reset     = 1'b1;
  logic        run_i     = 1'b0;
  logic        beat_tick_i  = 1'b0;
  logic        frame_tick_i = 1'b0;
  logic [2:0]  hit_req_i  = 3'b000;
  logic [2:0]  pat_data_i = 3'b000;
  logic [2:0]  pat_addr_o;
  logic [8:0]  slot_active_o;
  logic [89:0] slot_pos_o;
  logic        hit_pulse_o, miss_pulse_o, overflow_pulse_o;
  logic [7:0]  score_o;

  int total = 0;
  int bad   = 0;

  note_lane_scheduler dut (
    .board_clk        (board_clk),
    .reset            (reset),
    .run_i            (run_i),
    .beat_tick_i      (beat_tick_i),
    .frame_tick_i     (frame_tick_i),
    .hit_req_i        (hit_req_i),
    .pat_addr_o       (pat_addr_o),
    .pat_data_i       (pat_data_i),
    .slot_active_o    (slot_active_o),
    .slot_pos_o       (slot_pos_o),
    .hit_pulse_o      (hit_pulse_o),
    .miss_pulse_o     (miss_pulse_o),
    .overflow_pulse_o (overflow_pulse_o),
    .score_o          (score_o)
  );

  always #5 board_clk = ~board_clk;

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    beat_tick_i = 1'b0; frame_tick_i = 1'b0; hit_req_i = 3'b000;
    step();
    step();
    reset = 1'b0;
    run_i = 1'b1;
    step();
  endtask

  // Full beat: slots update on the 4th edge after beat_tick is sampled
  task automatic beat();
    beat_tick_i = 1'b1;
    step();
    beat_tick_i = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic frames(input int n);
    frame_tick_i = 1'b1;
    repeat (n) step();
    frame_tick_i = 1'b0;
  endtask

  function automatic logic [31:0] pos(input int k);
    return {22'd0, slot_pos_o[k*10 +: 10]};
  endfunction

  initial begin
    // reset state
    step();
    check("rst_active", {23'd0, slot_active_o}, 32'd0);
    check("rst_pos",    {2'd0, slot_pos_o[29:0]}, 32'd0);
    check("rst_addr",   {29'd0, pat_addr_o}, 32'd0);
    check("rst_score",  {24'd0, score_o}, 32'd0);
    check("rst_pulses", {29'd0, hit_pulse_o, miss_pulse_o, overflow_pulse_o}, 32'd0);

    // single red spawn latency
    reset = 1'b0;
    run_i = 1'b1;
    pat_data_i = 3'b100;
    step();
    beat_tick_i = 1'b1;
    step();
    beat_tick_i = 1'b0;
    step();
    step();
    check("spawn_not_early", {23'd0, slot_active_o}, 32'd0);
    step();
    check("spawn_active", {23'd0, slot_active_o}, 32'd1);
    check("spawn_pos",    pos(0), 32'd20);
    check("spawn_addr",   {29'd0, pat_addr_o}, 32'd1);

    // fill red lane then overflow
    beat();
    check("fill2", {23'd0, slot_active_o}, 32'd3);
    beat();
    check("fill3", {23'd0, slot_active_o}, 32'd7);
    check("no_ovf_yet", {31'd0, overflow_pulse_o}, 32'd0);
    beat();
    check("ovf_pulse", {31'd0, overflow_pulse_o}, 32'd1);
    check("ovf_slots", {23'd0, slot_active_o}, 32'd7);
    step();
    check("ovf_one_cycle", {31'd0, overflow_pulse_o}, 32'd0);
    check("addr_after4", {29'd0, pat_addr_o}, 32'd4);

    // scroll to bottom and retire
    do_reset();
    pat_data_i = 3'b100;
    beat();
    frames(440);
    check("bottom_pos", pos(0), 32'd460);
    check("bottom_active", {23'd0, slot_active_o}, 32'd1);
    check("no_miss_yet", {31'd0, miss_pulse_o}, 32'd0);
    frames(1);
    check("retire_active", {23'd0, slot_active_o}, 32'd0);
    check("miss_pulse", {31'd0, miss_pulse_o}, 32'd1);
    step();
    check("miss_one_cycle", {31'd0, miss_pulse_o}, 32'd0);

    // run=0 freeze, hit outside window, hit at window edge with frame_tick
    do_reset();
    pat_data_i = 3'b100;
    beat();
    run_i = 1'b0;
    frames(1);
    check("freeze_pos", pos(0), 32'd20);
    run_i = 1'b1;
    frames(379);
    check("pos399", pos(0), 32'd399);
    hit_req_i = 3'b100;
    step();
    hit_req_i = 3'b000;
    check("hit399_active", {23'd0, slot_active_o}, 32'd1);
    check("hit399_pulse", {31'd0, hit_pulse_o}, 32'd0);
    check("hit399_score", {24'd0, score_o}, 32'd0);
    frames(1);
    check("pos400", pos(0), 32'd400);
    hit_req_i = 3'b100;
    frame_tick_i = 1'b1;
    step();
    hit_req_i = 3'b000;
    frame_tick_i = 1'b0;
    check("hit400_active", {23'd0, slot_active_o}, 32'd0);
    check("hit400_pulse", {31'd0, hit_pulse_o}, 32'd1);
    check("hit400_score", {24'd0, score_o}, 32'd1);
    check("hit_no_miss", {31'd0, miss_pulse_o}, 32'd0);
    step();
    check("hit_one_cycle", {31'd0, hit_pulse_o}, 32'd0);

    // green lane lowest-index priority; empty blue lane hit ignored
    do_reset();
    pat_data_i = 3'b010;
    beat();
    check("green_slot3", {23'd0, slot_active_o}, 32'h008);
    frames(10);
    beat();
    check("green_slot34", {23'd0, slot_active_o}, 32'h018);
    frames(380);
    check("green_pos3", pos(3), 32'd410);
    check("green_pos4", pos(4), 32'd400);
    hit_req_i = 3'b011;
    step();
    hit_req_i = 3'b000;
    check("green_hit_active", {23'd0, slot_active_o}, 32'h010);
    check("green_hit_pos4", pos(4), 32'd400);
    check("green_hit_score", {24'd0, score_o}, 32'd1);
    check("green_hit_pulse", {31'd0, hit_pulse_o}, 32'd1);

    // address wrap, then asynchronous reset in SPAWN
    do_reset();
    pat_data_i = 3'b100;
    repeat (3) beat();
    pat_data_i = 3'b000;
    repeat (4) beat();
    check("addr7", {29'd0, pat_addr_o}, 32'd7);
    beat();
    check("addr_wrap", {29'd0, pat_addr_o}, 32'd0);
    check("wrap_slots", {23'd0, slot_active_o}, 32'd7);
    pat_data_i = 3'b100;
    beat_tick_i = 1'b1;
    step();
    beat_tick_i = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("async_active", {23'd0, slot_active_o}, 32'd0);
    check("async_pos0", pos(0), 32'd0);
    check("async_addr", {29'd0, pat_addr_o}, 32'd0);
    check("async_pulses", {29'd0, hit_pulse_o, miss_pulse_o, overflow_pulse_o}, 32'd0);
    #2;
    reset = 1'b0;
    step();
    check("post_rst_ovf", {31'd0, overflow_pulse_o}, 32'd0);
    check("post_rst_active", {23'd0, slot_active_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
